// File: rtl/color_cursor.sv
// color_cursor: cursor and selection controller for the 3x4 palette screen.
// Turns debounced direction buttons into a highlighted color_id (row*4+col)
// with hold-to-repeat, and latches a confirmed selection until cleared.
// Optional feature macro: CURSOR_WRAP_EN (edge moves wrap instead of saturating).
module color_cursor #(
    parameter int unsigned REPEAT_DELAY = 12_500_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_ok,
    input  logic       btn_clr,
    output logic [3:0] color_id,
    output logic [3:0] sel_id,
    output logic       sel_valid,
    output logic       locked
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [23:0] DELAY_LOAD = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RATE_LOAD  = 24'(REPEAT_RATE - 1);

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic [3:0]  r_dir;
    logic [3:0]  w_dir_nxt;
    logic [1:0]  r_row;
    logic [1:0]  r_col;
    logic [1:0]  w_row_nxt;
    logic [1:0]  w_col_nxt;
    logic        r_ok_prev;
    logic [3:0]  r_sel_id;
    logic        r_sel_valid;
    logic        r_locked;

    logic [3:0]  w_dir;
    logic        w_dir_one;
    logic        w_move;
    logic [3:0]  w_move_dir;
    logic        w_confirm;
    logic        w_hold;

    assign w_dir     = {btn_up, btn_down, btn_left, btn_right};
    assign w_dir_one = (w_dir != 4'd0) && ((w_dir & (w_dir - 4'd1)) == 4'd0);

    // Clear beats a simultaneous confirm edge; confirm is ignored while locked.
    assign w_confirm = btn_ok && !r_ok_prev && !r_locked && !btn_clr;
    // A confirm in this cycle already blocks moves, so sel_id gets the pre-move index.
    assign w_hold    = r_locked || w_confirm;

    // Next-state and repeat-timer control.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_move      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dir_one && !w_hold) begin
                    w_move      = 1'b1;
                    w_cnt_nxt   = DELAY_LOAD;
                    w_dir_nxt   = w_dir;
                    w_state_nxt = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                // r_dir is always one-hot here, so any mismatch covers release,
                // a different direction, or a multi-button chord.
                if (w_hold || (w_dir != r_dir)) begin
                    w_cnt_nxt   = 24'd0;
                    w_dir_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 24'd0) begin
                    w_move      = 1'b1;
                    w_cnt_nxt   = RATE_LOAD;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: begin
                w_cnt_nxt   = 24'd0;
                w_dir_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_move_dir = (r_state == S_IDLE) ? w_dir : r_dir;

    // Cursor arithmetic: saturate at the grid edges, or wrap when enabled.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_move) begin
            case (w_move_dir)
                DIR_UP:    w_row_nxt = (r_row == 2'd0) ? (WRAP_EN ? 2'd2 : 2'd0) : r_row - 2'd1;
                DIR_DOWN:  w_row_nxt = (r_row == 2'd2) ? (WRAP_EN ? 2'd0 : 2'd2) : r_row + 2'd1;
                DIR_LEFT:  w_col_nxt = (r_col == 2'd0) ? (WRAP_EN ? 2'd3 : 2'd0) : r_col - 2'd1;
                DIR_RIGHT: w_col_nxt = (r_col == 2'd3) ? (WRAP_EN ? 2'd0 : 2'd3) : r_col + 2'd1;
                default: begin
                    w_row_nxt = r_row;
                    w_col_nxt = r_col;
                end
            endcase
        end
    end

    // FSM, timer and cursor registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 24'd0;
            r_dir   <= 4'd0;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Confirm/clear handling; ok history resets high so a held button never confirms.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_ok_prev   <= 1'b1;
            r_sel_id    <= 4'd0;
            r_sel_valid <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_ok_prev   <= btn_ok;
            r_sel_valid <= w_confirm;
            if (w_confirm) begin
                r_sel_id <= {r_row, r_col};
            end
            if (btn_clr) begin
                r_locked <= 1'b0;
            end else if (w_confirm) begin
                r_locked <= 1'b1;
            end
        end
    end

    // row*4+col with col in 0..3 is exactly the concatenation.
    assign color_id  = {r_row, r_col};
    assign sel_id    = r_sel_id;
    assign sel_valid = r_sel_valid;
    assign locked    = r_locked;

endmodule

// File: doc/color_cursor.md
# color_cursor

Cursor and selection controller for the 3×4 colour palette screen. It turns debounced direction and confirm buttons into the highlighted `color_id` (0–11) consumed by the palette renderer. Held buttons auto-repeat. A confirm press latches a selection for the game logic downstream. The block sits between the button debouncers and the VGA palette/screen block, clocked on the pixel clock.

## Interface
Parameters
- `REPEAT_DELAY`, 12_500_000: cycles a direction must be held before the first auto-repeat move (0.5 s at 25 MHz); legal range 2..2^24-1.
- `REPEAT_RATE`, 2_500_000: cycles between subsequent auto-repeat moves; legal range 2..2^24-1.

Ports
- `pclk` in 1: pixel clock; all state updates on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced, pclk-synchronous, level-high.
- `btn_ok` in 1: debounced confirm, level-high.
- `btn_clr` in 1: debounced unlock, level-high.
- `color_id` out 4: cursor index = row*4 + col, range 0..11; drives the renderer highlight.
- `sel_id` out 4: last confirmed index.
- `sel_valid` out 1: one-cycle pulse when `sel_id` is updated.
- `locked` out 1: high after a confirm, until cleared.

## Operation
- Cursor state: `row` (0..2) and `col` (0..3), registered. `color_id = {row,col}` mapped as row*4+col, driven from registers.
- Direction vector `dir = {up,down,left,right}`. It is valid only when exactly one bit is set. Zero bits or two or more bits count as "no direction", and the FSM returns to IDLE.
- FSM states and transitions:
  - IDLE → DELAY on a valid dir while unlocked. One move is performed on this transition. Counter loads REPEAT_DELAY-1.
  - DELAY: counter decrements each cycle. At 0 and same dir still held: one move, counter loads REPEAT_RATE-1, go to REPEAT.
  - REPEAT: counter decrements each cycle. At 0: one move, reload REPEAT_RATE-1.
  - DELAY/REPEAT → IDLE when dir changes (different bit, released, or multi-bit) or when `locked` rises. The counter is discarded. A different single dir seen in the same cycle is not acted on until the next cycle in IDLE.
- Moves: up row-1, down row+1, left col-1, right col+1. Edge behaviour depends on `CURSOR_WRAP_EN` (see Configuration).
- Confirm: a rising edge of `btn_ok` (registered previous value) while unlocked does three things. `sel_id` ← current `color_id`. `sel_valid` = 1 for one cycle. `locked` ← 1. While locked, `btn_ok` edges are ignored.
- Clear: `btn_clr` high clears `locked` next edge. `sel_id` is retained. If `btn_clr` and an `btn_ok` edge occur in the same cycle, clear wins and no selection happens.
- Simultaneous confirm and direction move in one cycle: the move is suppressed because locked takes effect. `sel_id` captures the pre-move `color_id`.
- Reset values: row=0, col=0, `color_id`=0, `sel_id`=0, `sel_valid`=0, `locked`=0, FSM=IDLE, counter=0, btn_ok history=1. The history value of 1 means a button held through reset does not confirm. Reset mid-hold returns to IDLE; a still-held dir then moves again one cycle after reset deasserts.

## Timing
- Move latency: dir sampled high at edge k → `color_id` new value visible after edge k (one register stage).
- First repeat move occurs exactly REPEAT_DELAY cycles after the initial move. Later moves follow every REPEAT_RATE cycles.
- `sel_valid` is high for exactly one cycle, coincident with the new `sel_id`, one edge after `btn_ok` is first sampled high.
- `locked` rises on the same edge as `sel_valid`.
- The counter is 24 bits unsigned and never underflows: reload happens at 0.

## Configuration
- `CURSOR_WRAP_EN` defined: moves wrap within the row or column. Left at col 0 → col 3. Right at col 3 → col 0. Up at row 0 → row 2. Down at row 2 → row 0. Rows never change on left/right.
- Not defined: moves saturate. An edge move leaves row/col unchanged. FSM timing is unaffected, so repeats continue with no effect.

## Test plan
- Use REPEAT_DELAY=8, REPEAT_RATE=3 throughout.
- Reset, pulse `btn_right` one cycle three times → `color_id` 1, 2, 3. Fourth pulse → 3 (no wrap) or 0 (`CURSOR_WRAP_EN`).
- Hold `btn_down` 20 cycles from id 0 → moves at cycles 0, 8, 11, 14, 17. Rows go 1, 2, then saturate at 2 (id 8), or wrap to 0,1,2 (ids 4,8,0,4,8).
- Hold `btn_left` and `btn_up` together → `color_id` unchanged, FSM stays IDLE.
- Move to id 6, assert `btn_ok` → `sel_id`=6, `sel_valid` single-cycle pulse, `locked`=1. Further `btn_right`/`btn_ok` → no change. Then `btn_clr` → `locked`=0, `sel_id` stays 6.
- Hold `btn_right` across a 2-cycle `reset` → all outputs 0 during reset. `color_id`=1 one cycle after release.
- Assert `btn_ok` and `btn_clr` same cycle while unlocked → no `sel_valid`, `locked` stays 0.
